// File: rtl/mac_pkg.sv
// Shared types and width derivation for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BW_DEF    = 16;
  localparam int unsigned GUARD_DEF = 8;
  localparam int unsigned ACC_W     = 2 * BW_DEF + GUARD_DEF;

  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned guard);
    return 2 * bw + guard;
  endfunction

endpackage

// File: rtl/kogge_stone_Nbit_NOCLK.sv
// Combinational bw-bit Kogge-Stone parallel-prefix adder with carry in/out.
module kogge_stone_Nbit_NOCLK #(
  parameter int unsigned bw = 8
) (
  input  logic [bw-1:0] a,
  input  logic [bw-1:0] b,
  input  logic          cin,
  output logic [bw-1:0] sum,
  output logic          cout
);

  localparam int unsigned LV = (bw > 1) ? $clog2(bw) : 1;

  logic [bw-1:0] g [0:LV];
  logic [bw-1:0] p [0:LV];
  logic [bw:0]   c;

  always_comb begin
    g[0] = a & b;
    p[0] = a ^ b;
    for (int unsigned l = 0; l < LV; l++) begin
      g[l+1] = g[l];
      p[l+1] = p[l];
      for (int unsigned i = (32'd1 << l); i < bw; i++) begin
        g[l+1][i] = g[l][i] | (p[l][i] & g[l][i - (32'd1 << l)]);
        p[l+1][i] = p[l][i] & p[l][i - (32'd1 << l)];
      end
    end
  end

  // Group generate/propagate spanning bit 0 folds cin into every carry.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < bw; i++) begin
      c[i+1] = g[LV][i] | (p[LV][i] & cin);
    end
  end

  assign sum  = p[0] ^ c[bw-1:0];
  assign cout = c[bw];

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums vec_len products, presents result on valid/ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int unsigned BW    = 16,
  parameter  int unsigned GUARD = 8,
  parameter  int unsigned LEN_W = 8,
  localparam int unsigned AW    = acc_width(BW, GUARD)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic            prod_valid,
  input  logic [2*BW-1:0] prod,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [AW-1:0]   res,
  output logic            ovf
);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    res_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_sum;
  logic             acc_cout;
  logic             start_ok;
  logic             last;

  assign addend = AW'(prod);

  kogge_stone_Nbit_NOCLK #(.bw(AW)) u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_cout)
  );

  // A start is honoured in IDLE, or in DONE only on the handshake cycle.
  assign start_ok = start && ((state_q == IDLE) || ((state_q == DONE) && res_ready));
  assign last     = (count == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (vec_len == '0) ? DONE : ACC;
      end
      ACC: begin
        if (prod_valid && last) state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          if (start) state_d = (vec_len == '0) ? DONE : ACC;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      acc     <= '0;
      res_q   <= '0;
      count   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q <= vec_len;
        acc   <= '0;
        count <= '0;
        ovf_q <= 1'b0;
        if (vec_len == '0) res_q <= '0;
      end else if ((state_q == ACC) && prod_valid) begin
        acc   <= acc_sum;
        count <= count + LEN_W'(1);
        if (acc_cout) ovf_q <= 1'b1;
        if (last)     res_q <= acc_sum;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the registered unsigned product from the bw-bit array multiplier.
- Accumulates a run-time-programmed number of valid products into a dot-product sum.
- Presents the sum on a valid/ready output handshake and flags unsigned overflow.
- Sits between the multiplier output register and the result writeback logic.

Parameters:
- BW, 16, operand width of the upstream multiplier; the product is 2*BW bits.
- GUARD, 8, extra accumulator MSBs; ACC_W = 2*BW + GUARD.
- LEN_W, 8, width of the run-time vector-length input.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE, or in DONE on the handshake cycle.
- vec_len  in  LEN_W  number of products to accumulate; latched on an accepted start.
- prod_valid  in  1  prod carries a valid product this cycle.
- prod  in  2*BW  unsigned product from the multiplier output register.
- busy  out  1  high in ACC and DONE.
- res_valid  out  1  res holds a completed sum.
- res_ready  in  1  downstream accepts res.
- res  out  ACC_W  accumulated unsigned sum.
- ovf  out  1  sticky; set when any add carries out of ACC_W bits.

Behaviour:
- Reset (RESET=1 at a clock edge, any state, including mid-accumulation):
  - state=IDLE; acc, res, count, len_q all 0.
  - res_valid=0, busy=0, ovf=0.
  - The partial sum is discarded.
- States: IDLE, ACC, DONE. Encoding is 2 bits.
- IDLE:
  - prod_valid is ignored.
  - On start: len_q<=vec_len, acc<=0, count<=0, ovf<=0.
  - If vec_len==0, go directly to DONE with res=0 and res_valid=1 on the next cycle. Otherwise go to ACC.
- ACC:
  - Each cycle with prod_valid=1: acc<=acc+zero-extended prod, count<=count+1. Cycles with prod_valid=0 hold all state.
  - The add wraps modulo 2^ACC_W. A carry-out sets ovf; ovf stays set until the next accepted start.
  - When prod_valid=1 and count==len_q-1: res<=acc+prod (the same wrapped value), next state DONE.
  - res_valid=1 from the first DONE cycle, i.e. one cycle after the last product is accepted.
  - start is ignored in ACC.
- DONE:
  - res, res_valid and ovf are held stable while res_ready=0.
  - prod_valid is ignored.
  - On res_ready=1: res_valid<=0, next state IDLE.
  - If start=1 in the same cycle: the start is accepted exactly as in IDLE (latch vec_len, clear acc/count/ovf), next state ACC, or DONE if vec_len==0.
  - res keeps its last value until overwritten by the next completion.
- Throughput: one product per cycle in ACC, no stall cycles. prod_valid has no backpressure; the upstream must not present products outside ACC.
- Latency: last accepted product to res_valid=1 is 1 cycle.
- count width is LEN_W. A vec_len of 2^LEN_W-1 is legal.

Decomposition:
- Package mac_pkg holds:
  - the state encoding constants (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - the ACC_W derivation as a localparam.
- Sub-module: the accumulate adder is an instance of kogge_stone_Nbit_NOCLK with bw=ACC_W and cin=0.
  - Its cout feeds the ovf set logic.
  - The FSM, counter and result register stay in mac_accumulator.

Test Plan:
- Basic dot product, BW=16, vec_len=4: prods 6, 10, 15, 20 on consecutive cycles -> res=51, res_valid=1 one cycle after the 4th product, ovf=0.
- Bubbles: vec_len=3, prods 100, gap of 2 cycles, 200, gap, 300 -> res=600; count and acc hold during the gaps.
- Zero length: start with vec_len=0 -> DONE next cycle, res=0, res_valid=1, prod_valid pulses ignored.
- Backpressure and back-to-back:
  - First job: hold res_ready=0 for 5 cycles -> res and res_valid stable throughout.
  - Then assert res_ready=1 together with start and vec_len=2 -> the new job starts.
  - Second job: prods 1, 1 -> res=2, ovf=0.
- Overflow: GUARD=0, vec_len=2, prods 0xFFFFFFFF, 0x00000002 -> res=0x00000001, ovf=1; ovf clears on the next accepted start.
- Reset mid-operation: vec_len=4, 2 products accepted, RESET=1 for one cycle -> the next cycle shows IDLE, res=0, res_valid=0, busy=0; a new job with prods 5, 5, 5, 5 then gives res=20.
